oled_border_sequencer: RTL and testbench
========================================

# oled_border_sequencer

Sequencer for the OLED border/shape demo. It owns the timing of the orange→green border stages and the shape selection that the pixel renderer draws. It turns the raw `btnC`/`btnD` pins and the enable switch into a clean run/stop state machine, a stage index and a shape index. The OLED renderer consumes these outputs combinationally and has no timing logic of its own.

## Interface
Parameters:
- `T_STAGE0`, 200000000: cycles in stage 0 (orange only)
- `T_STAGE1`, 150000000: cycles in stage 1
- `T_STAGE2`, 100000000: cycles in stage 2
- `T_STAGE3`, 100000000: cycles in stage 3
- `DEBOUNCE`, 20000000: lockout cycles after an accepted press

Ports:
- `clk` in 1: system clock (100 MHz)
- `rst_n` in 1: asynchronous active-low reset
- `enable` in 1: level enable from `sw[1]`
- `btn_start` in 1: raw start pin (`btnC`), asynchronous
- `btn_shape` in 1: raw shape pin (`btnD`), asynchronous
- `running` out 1: 1 while in RUN (drives the orange border)
- `stage` out 2: green-border stage, 0..3
- `shape` out 2: 0 = none, 1..3 = shape id
- `stage_tick` out 1: 1-cycle pulse on every stage change
- `paused` out 1: 1 while in PAUSED (see Configuration)

## Operation
- Reset values: `running`=0, `stage`=0, `shape`=0, `stage_tick`=0, `paused`=0.
- Reset also clears all counters, synchronizer flops and lockouts.
- Button path (per button):
  - 2-flop synchronizer, then a delayed copy for edge detection.
  - `press` = synced & ~delayed & (lockout==0).
  - An accepted press loads lockout with `DEBOUNCE-1`. Lockout counts down to 0.
  - Edges arriving during lockout are discarded, not queued.
- States: IDLE, RUN, PAUSED (PAUSED exists only with the macro).
- IDLE:
  - Outputs are at reset values.
  - A start press with `enable`=1 goes to RUN with `stage`=0, stage counter=0, `shape`=0.
- RUN:
  - The stage counter increments each cycle.
  - When it equals `T_STAGEn-1`, it clears, `stage` advances (3 wraps to 0) and `stage_tick` pulses.
  - A shape press advances `shape` 0→1→2→3→1.
  - Without the macro, a start press in RUN is ignored; it does not restart.
- `enable`=0 in any state: go to IDLE on the next edge. All outputs take reset values and both lockouts clear. This has highest priority.
- Simultaneous events:
  - Start and shape presses in the same cycle while in IDLE: start is taken, shape is ignored.
  - Stage rollover and a shape press in the same cycle: both apply.
- Counter widths: `$clog2(max T_STAGEn)` bits for the stage counter and `$clog2(DEBOUNCE)` bits for each lockout. No overflow is possible.

## Timing
- Pin latency: a pin first sampled high at edge k produces the state/output change at edge k+2. `stage_tick` asserts for the cycle after that edge.
- Stage 0 lasts exactly `T_STAGE0` cycles from the RUN entry edge. Each later stage lasts exactly `T_STAGEn` cycles.
- One full loop is `T_STAGE0+T_STAGE1+T_STAGE2+T_STAGE3` cycles (550000000 by default).
- Minimum spacing between accepted presses of one button is `DEBOUNCE` cycles.
- `rst_n` deassertion is not synchronized internally; the top level supplies a synchronized release.

## Configuration
- `OLED_SEQ_PAUSE_EN` defined:
  - A start press in RUN goes to PAUSED and sets `paused`=1.
  - In PAUSED, the stage counter, `stage` and `shape` hold, shape presses are ignored, and `running` stays 1.
  - A start press in PAUSED returns to RUN and counting resumes from the held value.
  - `enable`=0 still forces IDLE.
- Not defined: PAUSED does not exist, `paused` is tied to 0, and start presses in RUN are ignored.

## Test plan
All scenarios use `T_STAGE0..3`=20/15/10/10 and `DEBOUNCE`=8.
- Reset, then `enable`=1 with no presses for 100 cycles → `running`=0, `stage`=0, `shape`=0, no `stage_tick`.
- Start pin high 1 cycle at edge k → `running`=1 at edge k+2. `stage` reads 1,2,3,0 at 20,35,45,55 cycles after entry, with one `stage_tick` per change.
- Shape presses spaced 10 cycles apart, 4 times, in RUN → `shape` goes 1,2,3,1. A second edge 3 cycles after an accepted press causes no change.
- Shape press in IDLE, and start+shape in the same cycle in IDLE → `shape` stays 0 and RUN is entered.
- `enable` dropped mid-stage-2 → next edge gives `running`=0, `stage`=0, `shape`=0. A start press 1 cycle later is accepted (lockout cleared).
- With the macro: start press at stage-1 cycle 5 gives `paused`=1 and `stage` frozen for 30 cycles. A second press resumes, and `stage` reaches 2 after 10 more stage cycles. Without the macro, the same stimulus leaves `paused`=0 and timing unchanged.

Source files
------------

// File: rtl/oled_border_sequencer.sv
// Run/stop sequencer for the OLED border demo: button conditioning, stage timing and shape select.
// Defining OLED_SEQ_PAUSE_EN adds a PAUSED state toggled by the start button while running.
module oled_border_sequencer #(
   parameter int T_STAGE0 = 200000000,
   parameter int T_STAGE1 = 150000000,
   parameter int T_STAGE2 = 100000000,
   parameter int T_STAGE3 = 100000000,
   parameter int DEBOUNCE = 20000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       btn_start,
   input  logic       btn_shape,
   output logic       running,
   output logic [1:0] stage,
   output logic [1:0] shape,
   output logic       stage_tick,
   output logic       paused
);
   localparam int T_MAX01 = (T_STAGE0 > T_STAGE1) ? T_STAGE0 : T_STAGE1;
   localparam int T_MAX23 = (T_STAGE2 > T_STAGE3) ? T_STAGE2 : T_STAGE3;
   localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
   localparam int CW      = (T_MAX > 2) ? $clog2(T_MAX) : 1;
   localparam int LW      = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [1:0]    stage_r, stage_nxt_s;
   logic [1:0]    shape_r, shape_nxt_s;
   logic          running_r, running_nxt_s;
   logic          tick_r, tick_nxt_s;
   logic          paused_r, paused_nxt_s;
   logic [2:0]    start_sync_r, shape_sync_r;
   logic [LW-1:0] start_lock_r, shape_lock_r;
   logic          press_start_s, press_shape_s;

   function automatic logic [CW-1:0] stage_last(input logic [1:0] s);
      case (s)
         2'd0:    stage_last = CW'(T_STAGE0 - 1);
         2'd1:    stage_last = CW'(T_STAGE1 - 1);
         2'd2:    stage_last = CW'(T_STAGE2 - 1);
         default: stage_last = CW'(T_STAGE3 - 1);
      endcase
   endfunction

   // Two synchronizer flops followed by a delay flop for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_sync_r <= 3'b000;
         shape_sync_r <= 3'b000;
      end else begin
         start_sync_r <= {start_sync_r[1:0], btn_start};
         shape_sync_r <= {shape_sync_r[1:0], btn_shape};
      end
   end

   assign press_start_s = start_sync_r[1] & ~start_sync_r[2] & (start_lock_r == {LW{1'b0}});
   assign press_shape_s = shape_sync_r[1] & ~shape_sync_r[2] & (shape_lock_r == {LW{1'b0}});

   // Post-press lockouts; edges seen while non-zero are dropped, disable clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_lock_r <= {LW{1'b0}};
         shape_lock_r <= {LW{1'b0}};
      end else if (!enable) begin
         start_lock_r <= {LW{1'b0}};
         shape_lock_r <= {LW{1'b0}};
      end else begin
         if (press_start_s)
            start_lock_r <= LW'(DEBOUNCE - 1);
         else if (start_lock_r != {LW{1'b0}})
            start_lock_r <= start_lock_r - LW'(1);
         else
            start_lock_r <= start_lock_r;
         if (press_shape_s)
            shape_lock_r <= LW'(DEBOUNCE - 1);
         else if (shape_lock_r != {LW{1'b0}})
            shape_lock_r <= shape_lock_r - LW'(1);
         else
            shape_lock_r <= shape_lock_r;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         stage_r   <= 2'd0;
         shape_r   <= 2'd0;
         running_r <= 1'b0;
         tick_r    <= 1'b0;
         paused_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         stage_r   <= stage_nxt_s;
         shape_r   <= shape_nxt_s;
         running_r <= running_nxt_s;
         tick_r    <= tick_nxt_s;
         paused_r  <= paused_nxt_s;
      end
   end

   // Next-state logic; disable overrides everything and returns to IDLE
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      stage_nxt_s = stage_r;
      shape_nxt_s = shape_r;
      tick_nxt_s  = 1'b0;
      if (!enable) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = {CW{1'b0}};
         stage_nxt_s = 2'd0;
         shape_nxt_s = 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_nxt_s   = {CW{1'b0}};
               stage_nxt_s = 2'd0;
               shape_nxt_s = 2'd0;
               if (press_start_s)
                  state_nxt_s = ST_RUN;
               else
                  state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
               if (cnt_r == stage_last(stage_r)) begin
                  cnt_nxt_s   = {CW{1'b0}};
                  stage_nxt_s = stage_r + 2'd1;
                  tick_nxt_s  = 1'b1;
               end else begin
                  cnt_nxt_s   = cnt_r + CW'(1);
               end
               if (press_shape_s)
                  shape_nxt_s = (shape_r == 2'd3) ? 2'd1 : shape_r + 2'd1;
               else
                  shape_nxt_s = shape_r;
`ifdef OLED_SEQ_PAUSE_EN
               if (press_start_s)
                  state_nxt_s = ST_PAUSED;
               else
                  state_nxt_s = ST_RUN;
`endif
            end
            ST_PAUSED: begin
`ifdef OLED_SEQ_PAUSE_EN
               if (press_start_s)
                  state_nxt_s = ST_RUN;
               else
                  state_nxt_s = ST_PAUSED;
`else
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CW{1'b0}};
               stage_nxt_s = 2'd0;
               shape_nxt_s = 2'd0;
`endif
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CW{1'b0}};
               stage_nxt_s = 2'd0;
               shape_nxt_s = 2'd0;
            end
         endcase
      end
      running_nxt_s = (state_nxt_s != ST_IDLE);
`ifdef OLED_SEQ_PAUSE_EN
      paused_nxt_s  = (state_nxt_s == ST_PAUSED);
`else
      paused_nxt_s  = 1'b0;
`endif
   end

   assign running    = running_r;
   assign stage      = stage_r;
   assign shape      = shape_r;
   assign stage_tick = tick_r;
   assign paused     = paused_r;
endmodule

// File: tb/tb_oled_border_sequencer.sv
// Self-checking bench for oled_border_sequencer: directed timing checks plus a randomized run
// compared every cycle against a behavioural model (honours OLED_SEQ_PAUSE_EN).
module tb_oled_border_sequencer;
   localparam int T0 = 20, T1 = 15, T2 = 10, T3 = 10, DB = 8;

   logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, btn_start = 1'b0, btn_shape = 1'b0;
   logic       running, stage_tick, paused;
   logic [1:0] stage, shape;
   int         n_checks = 0, n_fail = 0, cyc = 0, tick_cnt = 0;
   int         k, e, e2, tc0, p1;

   oled_border_sequencer #(
      .T_STAGE0(T0), .T_STAGE1(T1), .T_STAGE2(T2), .T_STAGE3(T3), .DEBOUNCE(DB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .btn_start(btn_start), .btn_shape(btn_shape),
      .running(running), .stage(stage), .shape(shape), .stage_tick(stage_tick), .paused(paused)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rst_n) tick_cnt <= tick_cnt + (stage_tick ? 1 : 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: mode 0 idle, 1 run, 2 paused; el = cycles elapsed in current stage
   typedef struct packed {
      int mode; int el; int st; int sh; int tk; int ls; int lp;
   } mst_t;
   mst_t       m;
   logic [2:0] m_hs, m_hp;

   function automatic int stage_len(input int s);
      case (s)
         0: return T0;
         1: return T1;
         2: return T2;
         default: return T3;
      endcase
   endfunction

   function automatic mst_t step(input mst_t s, input bit rise_s, input bit rise_p, input bit en);
      mst_t n = s;
      bit ps = rise_s && (s.ls == 0);
      bit pp = rise_p && (s.lp == 0);
      n.tk = 0;
      if (!en) begin
         n.mode = 0; n.el = 0; n.st = 0; n.sh = 0; n.ls = 0; n.lp = 0;
         return n;
      end
      n.ls = ps ? DB - 1 : (s.ls > 0 ? s.ls - 1 : 0);
      n.lp = pp ? DB - 1 : (s.lp > 0 ? s.lp - 1 : 0);
      if (s.mode == 0) begin
         if (ps) begin n.mode = 1; n.el = 0; n.st = 0; n.sh = 0; end
      end else if (s.mode == 1) begin
         n.el = s.el + 1;
         if (n.el == stage_len(s.st)) begin n.el = 0; n.st = (s.st + 1) % 4; n.tk = 1; end
         if (pp) n.sh = (s.sh == 3) ? 1 : s.sh + 1;
`ifdef OLED_SEQ_PAUSE_EN
         if (ps) n.mode = 2;
`endif
      end else begin
         if (ps) n.mode = 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m    <= '0;
         m_hs <= 3'b000;
         m_hp <= 3'b000;
      end else begin
         m    <= step(m, m_hs[1] & ~m_hs[2], m_hp[1] & ~m_hp[2], enable);
         m_hs <= {m_hs[1:0], btn_start};
         m_hp <= {m_hp[1:0], btn_shape};
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_running", running, (m.mode != 0) ? 1 : 0);
         chk("model_stage", stage, m.st);
         chk("model_shape", shape, m.sh);
         chk("model_tick", stage_tick, m.tk);
         chk("model_paused", paused, (m.mode == 2) ? 1 : 0);
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Pins are high for exactly the edge numbered p
   task automatic pulse(input bit s, input bit p, input int at);
      wait_until(at - 1);
      if (s) btn_start = 1'b1;
      if (p) btn_shape = 1'b1;
      wait_until(at);
      btn_start = 1'b0;
      btn_shape = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_running", running, 0);
      chk("reset_stage", stage, 0);
      chk("reset_shape", shape, 0);
      chk("reset_tick", stage_tick, 0);
      chk("reset_paused", paused, 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      k = cyc;
      wait_until(k + 100);
      chk("idle_running", running, 0);
      chk("idle_stage", stage, 0);
      chk("idle_ticks", tick_cnt, 0);

      // Start press and stage timing
      k = cyc + 2;
      pulse(1'b1, 1'b0, k);
      wait_until(k + 1);
      chk("start_latency_early", running, 0);
      wait_until(k + 2);
      chk("start_latency", running, 1);
      e = k + 2;
      tc0 = tick_cnt;
      wait_until(e + 19);
      chk("stage0_end", stage, 0);
      wait_until(e + 20);
      chk("stage1_at20", stage, 1);
      chk("model_pin_stage", m.st, 1);
      chk("tick_at20", stage_tick, 1);
      wait_until(e + 21);
      chk("tick_gone", stage_tick, 0);
      wait_until(e + 34);
      chk("stage1_end", stage, 1);
      wait_until(e + 35);
      chk("stage2_at35", stage, 2);
      wait_until(e + 45);
      chk("stage3_at45", stage, 3);
      wait_until(e + 55);
      chk("stage0_at55", stage, 0);
      wait_until(e + 56);
      chk("tick_count_loop", tick_cnt - tc0, 4);

      // Shape presses, with a bounce inside the lockout window
      p1 = e + 58;
      pulse(1'b0, 1'b1, p1);
      wait_until(p1 + 2);
      chk("shape_1", shape, 1);
      pulse(1'b0, 1'b1, p1 + 3);
      wait_until(p1 + 7);
      chk("shape_bounce", shape, 1);
      pulse(1'b0, 1'b1, p1 + 10);
      wait_until(p1 + 12);
      chk("shape_2", shape, 2);
      pulse(1'b0, 1'b1, p1 + 20);
      wait_until(p1 + 22);
      chk("shape_3", shape, 3);
      pulse(1'b0, 1'b1, p1 + 30);
      wait_until(p1 + 32);
      chk("shape_wrap", shape, 1);
      chk("rollover_with_shape", stage, 2);

      // Enable drop mid stage 2, then lockout clearing
      wait_until(e + 94);
      chk("mid_stage2", stage, 2);
      enable = 1'b0;
      wait_until(e + 95);
      chk("disable_running", running, 0);
      chk("disable_stage", stage, 0);
      chk("disable_shape", shape, 0);
      enable = 1'b1;
      pulse(1'b1, 1'b0, e + 96);
      wait_until(e + 98);
      chk("restart_after_disable", running, 1);
      enable = 1'b0;
      wait_until(e + 99);
      chk("disable2_running", running, 0);
      enable = 1'b1;
      pulse(1'b1, 1'b0, e + 100);
      wait_until(e + 102);
      chk("lockout_cleared", running, 1);

      // Shape press in IDLE, then simultaneous start+shape in IDLE
      enable = 1'b0;
      wait_until(e + 103);
      enable = 1'b1;
      pulse(1'b0, 1'b1, e + 105);
      wait_until(e + 110);
      chk("idle_shape_ignored", shape, 0);
      chk("idle_shape_norun", running, 0);
      pulse(1'b1, 1'b1, e + 112);
      wait_until(e + 114);
      chk("both_run", running, 1);
      chk("both_shape", shape, 0);
      e2 = e + 114;

      // Start press at stage-1 cycle 5
      pulse(1'b1, 1'b0, e2 + 23);
      wait_until(e2 + 25);
      chk("pause_stage", stage, 1);
`ifdef OLED_SEQ_PAUSE_EN
      chk("pause_flag", paused, 1);
      wait_until(e2 + 55);
      chk("pause_hold_stage", stage, 1);
      chk("pause_hold_flag", paused, 1);
      chk("pause_running", running, 1);
      pulse(1'b1, 1'b0, e2 + 56);
      wait_until(e2 + 58);
      chk("resume_flag", paused, 0);
      wait_until(e2 + 67);
      chk("resume_stage1", stage, 1);
      wait_until(e2 + 68);
      chk("resume_stage2", stage, 2);
`else
      chk("nopause_flag", paused, 0);
      wait_until(e2 + 34);
      chk("nopause_stage1", stage, 1);
      wait_until(e2 + 35);
      chk("nopause_stage2", stage, 2);
      chk("nopause_running", running, 1);
`endif

      // Randomized run, checked by the model every cycle
      repeat (4000) begin
         @(negedge clk);
         enable = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 4) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 3) == 0) btn_shape = ~btn_shape;
      end
      btn_start = 1'b0;
      btn_shape = 1'b0;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
